// File: rtl/music_output_stage.sv
// Output stage for the YM music player: centres the 10-bit PSG sample, applies master volume with
// vblank-timed fade ramps and mute. Optional MUSIC_DCBLOCK_EN replaces fixed centring with an adaptive DC estimate.
module music_output_stage #(
  parameter int FADE_CNT_W = 8,
  parameter int OUT_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_2,
  input  logic        vblank,
  input  logic [1:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        write,
  input  logic [9:0]  sound_in,
  output logic [15:0] audio_out,
  output logic        fade_busy
);

  typedef enum logic {IDLE, RAMP} state_t;

  // Wide enough to compare counter+1 against the 8-bit rate without wrap.
  localparam int CMP_W = ((FADE_CNT_W > 8) ? FADE_CNT_W : 8) + 1;

  state_t                state;
  logic [7:0]            target;
  logic [7:0]            rate;
  logic [7:0]            cur_vol;
  logic                  mute;
  logic                  vblank_last;
  logic [FADE_CNT_W-1:0] cnt;
  logic signed [10:0]    s1;

  logic                  tick;
  logic                  wr_target;
  logic                  wr_rate;
  logic                  wr_ctrl;
  logic [7:0]            tgt_eff;
  logic [7:0]            stepped;
  logic                  step_due;
  logic signed [10:0]    centred;
  logic signed [19:0]    product;
  logic signed [19:0]    scaled;

  assign tick      = vblank && !vblank_last;
  assign wr_target = write && (addr == 2'd0);
  assign wr_rate   = write && (addr == 2'd1);
  assign wr_ctrl   = write && (addr == 2'd2);

  // A target write landing with a tick steps toward the new target.
  assign tgt_eff  = wr_target ? data_in : target;
  assign stepped  = (tgt_eff > cur_vol) ? cur_vol + 8'd1 : cur_vol - 8'd1;
  assign step_due = (CMP_W'(cnt) + CMP_W'(1)) == CMP_W'(rate);

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      target      <= 8'd0;
      rate        <= 8'd0;
      mute        <= 1'b0;
      cur_vol     <= 8'd0;
      cnt         <= '0;
      fade_busy   <= 1'b0;
      vblank_last <= 1'b0;
    end else begin
      vblank_last <= vblank;
      if (wr_target) target <= data_in;
      if (wr_rate)   rate   <= data_in;
      if (wr_ctrl)   mute   <= data_in[0];

      unique case (state)
        IDLE: begin
          if (wr_target) begin
            if (rate == 8'd0) begin
              cur_vol <= data_in;
            end else if (data_in != cur_vol) begin
              state     <= RAMP;
              cnt       <= '0;
              fade_busy <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (wr_rate && (data_in == 8'd0)) begin
            cur_vol   <= target;
            cnt       <= '0;
            state     <= IDLE;
            fade_busy <= 1'b0;
          end else if (tgt_eff == cur_vol) begin
            cnt       <= '0;
            state     <= IDLE;
            fade_busy <= 1'b0;
          end else if (tick) begin
            if (step_due) begin
              cnt     <= '0;
              cur_vol <= stepped;
              if (stepped == tgt_eff) begin
                state     <= IDLE;
                fade_busy <= 1'b0;
              end
            end else begin
              cnt <= cnt + FADE_CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef MUSIC_DCBLOCK_EN
  logic [17:0]        acc;
  logic signed [11:0] diff;

  assign diff = $signed({2'b00, sound_in}) - $signed({2'b00, acc[17:8]});

  always_comb begin
    if (diff > 12'sd511)        centred = 11'sd511;
    else if (diff < -12'sd512)  centred = 11'b100_0000_0000;
    else                        centred = diff[10:0];
  end

  // Leaky integrator: acc[17:8] tracks the mean of sound_in with a 256-sample time constant.
  always_ff @(posedge clk) begin
    if (reset)     acc <= 18'd131072;
    else if (ce_2) acc <= acc + 18'(sound_in) - 18'(acc[17:8]);
  end
`else
  assign centred = $signed({1'b0, sound_in} - 11'd512);
`endif

  assign product = 20'(s1) * $signed({12'b0, cur_vol});
  assign scaled  = product >>> OUT_SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      audio_out <= 16'd0;
    end else if (ce_2) begin
      s1        <= centred;
      audio_out <= mute ? 16'd0 : scaled[15:0];
    end
  end

endmodule
